// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types and helpers for the Fifo enqueue arbiter
package fifo_arb_pkg;

  localparam int XFER_CNT_W = 16;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_st_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_enq_arbiter_rr_pick.sv
// rtl/fifo_enq_arbiter_rr_pick.sv - rotating-priority picker starting at a base index
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]        req,
  input  logic [clog2(N)-1:0] base,
  output logic [N-1:0]        pick,
  output logic [clog2(N)-1:0] idx
);

  localparam int IDW = clog2(N);

  logic           found;
  logic [IDW-1:0] j;

  always_comb begin
    pick  = '0;
    idx   = '0;
    found = 1'b0;
    j     = '0;
    for (int off = 0; off < N; off++) begin
      j = IDW'((int'(base) + off) % N);
      if (!found && req[j]) begin
        found   = 1'b1;
        pick[j] = 1'b1;
        idx     = j;
      end
    end
  end

endmodule

// File: rtl/fifo_enq_arbiter.sv
// rtl/fifo_enq_arbiter.sv - round-robin arbiter with burst lock onto one Fifo enqueue port
module fifo_enq_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N         = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N-1:0]                 req,
  input  logic [N*WIDTH-1:0]           req_data,
  output logic [N-1:0]                 gnt,
  input  logic                         fifo_enq_rdy,
  output logic                         fifo_enq_en,
  output logic [clog2(N)+WIDTH-1:0]    fifo_enq_val,
  output logic [XFER_CNT_W-1:0]        xfer_cnt
);

  localparam int IDW = clog2(N);
  localparam int BW  = clog2(MAX_BURST) + 1;

  function automatic logic [IDW-1:0] inc(input logic [IDW-1:0] x);
    return (x == IDW'(N - 1)) ? '0 : x + 1'b1;
  endfunction

  arb_st_t        st;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] owner;
  logic [BW-1:0]  bcnt;

  logic           lock_hit;
  logic           xfer;
  logic [IDW-1:0] base;
  logic [IDW-1:0] sel;
  logic [N-1:0]   pick;
  logic [IDW-1:0] pick_idx;

  // While locked the scan skips the owner, so a dropped owner yields fairly.
  assign lock_hit = (st == LOCK) && req[owner];
  assign base     = (st == LOCK) ? inc(owner) : ptr;

  rr_pick #(.N(N)) u_pick (
    .req  (req),
    .base (base),
    .pick (pick),
    .idx  (pick_idx)
  );

  assign sel          = lock_hit ? owner : pick_idx;
  assign xfer         = rst_n & fifo_enq_rdy & (|req);
  assign fifo_enq_en  = xfer;
  assign gnt          = xfer ? (lock_hit ? (N'(1) << owner) : pick) : '0;
  assign fifo_enq_val = {sel, req_data[sel*WIDTH +: WIDTH]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st       <= IDLE;
      ptr      <= '0;
      owner    <= '0;
      bcnt     <= '0;
      xfer_cnt <= '0;
    end else if (xfer) begin
      xfer_cnt <= xfer_cnt + 1'b1;
      if (MAX_BURST == 1) begin
        ptr <= inc(sel);
      end else if (st == IDLE || sel != owner) begin
        st    <= LOCK;
        owner <= sel;
        bcnt  <= BW'(1);
      end else if (bcnt + BW'(1) == BW'(MAX_BURST)) begin
        st  <= IDLE;
        ptr <= inc(owner);
      end else begin
        bcnt <= bcnt + BW'(1);
      end
    end else if (st == LOCK && !req[owner]) begin
      st  <= IDLE;
      ptr <= inc(owner);
    end
  end

endmodule

// File: tb/tb_fifo_enq_arbiter.sv
// tb/tb_fifo_enq_arbiter.sv - directed vector bench for fifo_enq_arbiter
module tb_fifo_enq_arbiter;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  gnt;
  logic        rdy;
  logic        en;
  logic [9:0]  val;
  logic [15:0] cnt;

  logic        rst3_n;
  logic [2:0]  req3;
  logic [23:0] req_data3;
  logic [2:0]  gnt3;
  logic        rdy3;
  logic        en3;
  logic [9:0]  val3;
  logic [15:0] cnt3;

  fifo_enq_arbiter #(.N(4), .WIDTH(8), .MAX_BURST(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .req_data     (req_data),
    .gnt          (gnt),
    .fifo_enq_rdy (rdy),
    .fifo_enq_en  (en),
    .fifo_enq_val (val),
    .xfer_cnt     (cnt)
  );

  fifo_enq_arbiter #(.N(3), .WIDTH(8), .MAX_BURST(1)) dut3 (
    .clk          (clk),
    .rst_n        (rst3_n),
    .req          (req3),
    .req_data     (req_data3),
    .gnt          (gnt3),
    .fifo_enq_rdy (rdy3),
    .fifo_enq_en  (en3),
    .fifo_enq_val (val3),
    .xfer_cnt     (cnt3)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic        rdy;
    logic [3:0]  gnt;
    logic        en;
    logic [1:0]  tag;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;
  logic [7:0] dat [4] = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};
  logic [7:0] dat3 [3] = '{8'h00, 8'h11, 8'h22};

  task automatic add(input logic r, input logic [3:0] q, input logic y,
                     input logic [3:0] g, input logic e, input logic [1:0] t,
                     input logic [15:0] c);
    vec_t v;
    v.rst = r; v.req = q; v.rdy = y; v.gnt = g; v.en = e; v.tag = t; v.cnt = c;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input int row, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n_en;
    rst_n = 1'b0; req = 4'hF; rdy = 1'b1; req_data = 32'hD3C2B1A0;
    rst3_n = 1'b0; req3 = 3'b111; rdy3 = 1'b1; req_data3 = 24'h221100;
    next_cycle();

    // reset hold
    add(0, 4'b1111, 1, 4'b0000, 0, 0, 0);
    add(0, 4'b1111, 1, 4'b0000, 0, 0, 0);
    add(0, 4'b1111, 1, 4'b0000, 0, 0, 0);
    // burst then rotate: 0,0,1,1,2,2,3,3,0
    add(1, 4'b1111, 1, 4'b0001, 1, 0, 0);
    add(1, 4'b1111, 1, 4'b0001, 1, 0, 1);
    add(1, 4'b1111, 1, 4'b0010, 1, 1, 2);
    add(1, 4'b1111, 1, 4'b0010, 1, 1, 3);
    add(1, 4'b1111, 1, 4'b0100, 1, 2, 4);
    add(1, 4'b1111, 1, 4'b0100, 1, 2, 5);
    add(1, 4'b1111, 1, 4'b1000, 1, 3, 6);
    add(1, 4'b1111, 1, 4'b1000, 1, 3, 7);
    add(1, 4'b1111, 1, 4'b0001, 1, 0, 8);
    // owner 0 drops: scan from 1 finds 2; then 2 drops: scan from 3
    add(1, 4'b0100, 1, 4'b0100, 1, 2, 9);
    add(1, 4'b1001, 1, 4'b1000, 1, 3, 10);
    add(1, 4'b1001, 1, 4'b1000, 1, 3, 11);
    add(1, 4'b1001, 1, 4'b0001, 1, 0, 12);
    // idle cycle releases lock of owner 0, then owner 1 starts a burst
    add(1, 4'b0000, 1, 4'b0000, 0, 0, 13);
    add(1, 4'b0011, 1, 4'b0010, 1, 1, 13);
    // backpressure mid-burst keeps owner 1
    add(1, 4'b0110, 0, 4'b0000, 0, 0, 14);
    add(1, 4'b0110, 0, 4'b0000, 0, 0, 14);
    add(1, 4'b0110, 0, 4'b0000, 0, 0, 14);
    add(1, 4'b0110, 0, 4'b0000, 0, 0, 14);
    add(1, 4'b0110, 0, 4'b0000, 0, 0, 14);
    add(1, 4'b0110, 1, 4'b0010, 1, 1, 14);
    add(1, 4'b0110, 1, 4'b0100, 1, 2, 15);
    // mid-run reset, then lowest requesting index wins
    add(0, 4'b1111, 1, 4'b0000, 0, 0, 16);
    add(1, 4'b1100, 1, 4'b0100, 1, 2, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      rst_n = tbl[i].rst; req = tbl[i].req; rdy = tbl[i].rdy;
      #3;
      chk("gnt", i, 32'(gnt), 32'(tbl[i].gnt));
      chk("enq_en", i, 32'(en), 32'(tbl[i].en));
      chk("xfer_cnt", i, 32'(cnt), 32'(tbl[i].cnt));
      if (tbl[i].en) chk("enq_val", i, 32'(val), 32'({tbl[i].tag, dat[tbl[i].tag]}));
      next_cycle();
    end

    // pure round-robin on N=3 with modulo-3 wrap
    rst3_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      int k;
      k = i % 3;
      #3;
      chk("gnt3", i, 32'(gnt3), 32'(3'b001 << k));
      chk("enq_val3", i, 32'(val3), {22'd0, 2'(k), dat3[k]});
      chk("xfer_cnt3", i, 32'(cnt3), i);
      next_cycle();
    end

    // counter wrap over 2^16 beats
    rst_n = 1'b0; req = 4'hF; rdy = 1'b1;
    next_cycle();
    rst_n = 1'b1;
    n_en = 0;
    for (int i = 0; i < 65536; i++) begin
      #3;
      if (en) n_en++;
      next_cycle();
    end
    #3;
    chk("wrap_beats", 0, n_en, 65536);
    chk("wrap_cnt", 0, 32'(cnt), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
